// File: rtl/lab3_pkg.sv
// Shared Lab 3 types: checker FSM states, function-select codes, observed vector layout.
package lab3_pkg;

    localparam int unsigned MODE_HA = 0;
    localparam int unsigned MODE_HS = 1;

    localparam int unsigned VEC_W     = 4;
    localparam int unsigned VEC_A     = 3;
    localparam int unsigned VEC_B     = 2;
    localparam int unsigned VEC_SUM   = 1;
    localparam int unsigned VEC_CARRY = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Observed vector as it appears on the monitor: {a, b, sum, carry}
    typedef struct packed {
        logic a;
        logic b;
        logic sum;
        logic carry;
    } vec_t;

endpackage

// File: rtl/ha_ref_model.sv
// Golden half-adder / half-subtractor: expected {sum, carry} for one input pair.
module ha_ref_model
    import lab3_pkg::*;
#(
    parameter int unsigned MODE = MODE_HA
) (
    input  logic a,
    input  logic b,
    output logic exp_sum_c,
    output logic exp_carry_c
);

    // Difference equals sum; only the carry/borrow term depends on MODE
    always_comb begin
        exp_sum_c   = a ^ b;
        exp_carry_c = a & b;
        if (MODE == MODE_HS) begin
            exp_carry_c = ~a & b;
        end
    end

endmodule

// File: rtl/ha_response_checker.sv
// Scores observed half-adder/subtractor vectors against the reference model
// and produces a registered pass/fail verdict with coverage and first-failure capture.
module ha_response_checker
    import lab3_pkg::*;
#(
    parameter int unsigned MODE        = MODE_HA,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned MIN_VECTORS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_sum,
    input  logic             in_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] vec_cnt,
    output logic [3:0]       coverage,
    output logic             fail_valid,
    output logic [3:0]       fail_vec
);

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] MIN_VEC = ERR_W'(MIN_VECTORS);

    state_t           state;
    state_t           state_next;
    logic [ERR_W-1:0] err_next;
    logic [ERR_W-1:0] vec_next;
    logic [3:0]       cov_next;
    logic             fv_next;
    logic [3:0]       fvec_next;

    logic             exp_sum_c;
    logic             exp_carry_c;
    logic             accept_c;
    logic             mismatch_c;
    vec_t             obs_c;

    ha_ref_model #(.MODE(MODE)) u_ref (
        .a           (in_a),
        .b           (in_b),
        .exp_sum_c   (exp_sum_c),
        .exp_carry_c (exp_carry_c)
    );

    assign obs_c      = {in_a, in_b, in_sum, in_carry};
    assign accept_c   = in_valid & in_ready;
    assign mismatch_c = (in_sum != exp_sum_c) || (in_carry != exp_carry_c);

    // Next-state and next-result computation; a start always wins over a same-cycle accept
    always_comb begin
        state_next = state;
        err_next   = err_cnt;
        vec_next   = vec_cnt;
        cov_next   = coverage;
        fv_next    = fail_valid;
        fvec_next  = fail_vec;

        if (start) begin
            state_next = RUN;
            err_next   = '0;
            vec_next   = '0;
            cov_next   = '0;
            fv_next    = 1'b0;
            fvec_next  = '0;
        end else if (state == RUN && accept_c) begin
            vec_next = (vec_cnt == CNT_MAX) ? vec_cnt : vec_cnt + ERR_W'(1);
            cov_next = coverage | (4'(1) << {in_a, in_b});
            if (mismatch_c) begin
                err_next = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + ERR_W'(1);
                if (!fail_valid) begin
                    fv_next   = 1'b1;
                    fvec_next = obs_c;
                end
            end
            if (cov_next == 4'hF && vec_next >= MIN_VEC) begin
                state_next = DONE;
            end
        end
    end

    // State and registered outputs; status flags decode the next state so they align with results
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            vec_cnt    <= '0;
            coverage   <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            state      <= state_next;
            in_ready   <= (state_next == RUN);
            busy       <= (state_next == RUN);
            done       <= (state_next == DONE);
            pass       <= (state_next == DONE) && (err_next == '0);
            err_cnt    <= err_next;
            vec_cnt    <= vec_next;
            coverage   <= cov_next;
            fail_valid <= fv_next;
            fail_vec   <= fvec_next;
        end
    end

endmodule

// File: tb/tb_ha_response_checker.sv
// Scoreboard bench: a half-adder and a half-subtractor checker share one observed-vector stream.
module tb_ha_response_checker;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [7:0] vec;
        logic [3:0] cov;
        logic       fv;
        logic [3:0] fvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_ha = 1'b0;
    logic start_hs = 1'b0;
    logic in_valid = 1'b0;
    logic in_a = 1'b0, in_b = 1'b0, in_sum = 1'b0, in_carry = 1'b0;

    logic       ha_ready, ha_busy, ha_done, ha_pass, ha_fv;
    logic [7:0] ha_err, ha_vec;
    logic [3:0] ha_cov, ha_fvec;
    logic       hs_ready, hs_busy, hs_done, hs_pass, hs_fv;
    logic [7:0] hs_err, hs_vec;
    logic [3:0] hs_cov, hs_fvec;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q_ha[$];
    exp_t q_hs[$];

    always #5 clk = ~clk;

    ha_response_checker #(.MODE(0), .ERR_W(8), .MIN_VECTORS(4)) u_ha (
        .clk(clk), .rst(rst), .start(start_ha), .in_valid(in_valid), .in_ready(ha_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
        .busy(ha_busy), .done(ha_done), .pass(ha_pass), .err_cnt(ha_err), .vec_cnt(ha_vec),
        .coverage(ha_cov), .fail_valid(ha_fv), .fail_vec(ha_fvec)
    );

    ha_response_checker #(.MODE(1), .ERR_W(8), .MIN_VECTORS(4)) u_hs (
        .clk(clk), .rst(rst), .start(start_hs), .in_valid(in_valid), .in_ready(hs_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
        .busy(hs_busy), .done(hs_done), .pass(hs_pass), .err_cnt(hs_err), .vec_cnt(hs_vec),
        .coverage(hs_cov), .fail_valid(hs_fv), .fail_vec(hs_fvec)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [7:0] e, input logic [7:0] v,
                                input logic [3:0] c, input logic f, input logic [3:0] fv);
        exp_t r;
        r.pass = p; r.err = e; r.vec = v; r.cov = c; r.fv = f; r.fvec = fv;
        return r;
    endfunction

    // Present one vector for one clock; in_valid stays high so calls chain back-to-back
    task automatic send(input logic a, input logic b, input logic s, input logic c);
        in_valid = 1'b1; in_a = a; in_b = b; in_sum = s; in_carry = c;
        @(posedge clk); #1;
    endtask

    task automatic idle_bus();
        in_valid = 1'b0;
    endtask

    task automatic pulse_ha();
        start_ha = 1'b1; @(posedge clk); #1; start_ha = 1'b0;
    endtask

    task automatic wait_done_ha(input string name);
        int k;
        k = 0;
        while (ha_done !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk({name, "_done_timeout"}, 8'(ha_done), 8'd1);
    endtask

    task automatic chk_ha_reset(input string tag);
        chk({tag, "_ready"}, 8'(ha_ready), 8'd0);
        chk({tag, "_busy"},  8'(ha_busy),  8'd0);
        chk({tag, "_done"},  8'(ha_done),  8'd0);
        chk({tag, "_pass"},  8'(ha_pass),  8'd0);
        chk({tag, "_err"},   ha_err,       8'd0);
        chk({tag, "_vec"},   ha_vec,       8'd0);
        chk({tag, "_cov"},   8'(ha_cov),   8'd0);
        chk({tag, "_fv"},    8'(ha_fv),    8'd0);
        chk({tag, "_fvec"},  8'(ha_fvec),  8'd0);
    endtask

    // Monitor: each rising done pops that checker's expected verdict
    initial begin : monitor
        logic ha_q, hs_q;
        exp_t e;
        ha_q = 1'b0; hs_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ha_done && !ha_q) begin
                if (q_ha.size() == 0) chk("ha_unexpected_done", 8'd1, 8'd0);
                else begin
                    e = q_ha.pop_front();
                    chk("ha_pass", 8'(ha_pass), 8'(e.pass));
                    chk("ha_err",  ha_err, e.err);
                    chk("ha_vec",  ha_vec, e.vec);
                    chk("ha_cov",  8'(ha_cov), 8'(e.cov));
                    chk("ha_fv",   8'(ha_fv), 8'(e.fv));
                    chk("ha_fvec", 8'(ha_fvec), 8'(e.fvec));
                    chk("ha_busy_at_done",  8'(ha_busy), 8'd0);
                    chk("ha_ready_at_done", 8'(ha_ready), 8'd0);
                end
            end
            if (!rst && hs_done && !hs_q) begin
                if (q_hs.size() == 0) chk("hs_unexpected_done", 8'd1, 8'd0);
                else begin
                    e = q_hs.pop_front();
                    chk("hs_pass", 8'(hs_pass), 8'(e.pass));
                    chk("hs_err",  hs_err, e.err);
                    chk("hs_vec",  hs_vec, e.vec);
                    chk("hs_cov",  8'(hs_cov), 8'(e.cov));
                    chk("hs_fv",   8'(hs_fv), 8'(e.fv));
                    chk("hs_fvec", 8'(hs_fvec), 8'(e.fvec));
                end
            end
            ha_q = ha_done;
            hs_q = hs_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk_ha_reset("reset");
        chk("reset_hs_ready", 8'(hs_ready), 8'd0);
        chk("reset_hs_vec",   hs_vec, 8'd0);

        // Vectors offered while idle are ignored
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        idle_bus();
        @(negedge clk);
        chk("idle_vec", ha_vec, 8'd0);
        chk("idle_cov", 8'(ha_cov), 8'd0);

        // Half adder, four correct vectors
        q_ha.push_back(mk(1'b1, 8'd0, 8'd4, 4'hF, 1'b0, 4'h0));
        pulse_ha();
        @(negedge clk);
        chk("run_busy",  8'(ha_busy), 8'd1);
        chk("run_ready", 8'(ha_ready), 8'd1);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_not_done_3", 8'(ha_done), 8'd0);
        chk("t1_vec_3", ha_vec, 8'd3);
        send(1'b1, 1'b1, 1'b0, 1'b1);
        idle_bus();
        @(negedge clk);
        chk("t1_done_latency", 8'(ha_done), 8'd1);

        // Vectors after done are ignored, results frozen
        send(1'b0, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b0, 1'b1);
        idle_bus();
        @(negedge clk);
        chk("frozen_vec",  ha_vec, 8'd4);
        chk("frozen_err",  ha_err, 8'd0);
        chk("frozen_done", 8'(ha_done), 8'd1);
        chk("frozen_pass", 8'(ha_pass), 8'd1);

        // Two errors, first capture kept
        q_ha.push_back(mk(1'b0, 8'd2, 8'd4, 4'hF, 1'b1, 4'b1110));
        pulse_ha();
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        idle_bus();
        wait_done_ha("t2");

        // Subtractor stimulus scored by both checkers at once
        q_hs.push_back(mk(1'b1, 8'd0, 8'd4, 4'hF, 1'b0, 4'h0));
        q_ha.push_back(mk(1'b0, 8'd2, 8'd4, 4'hF, 1'b1, 4'b0111));
        start_ha = 1'b1; start_hs = 1'b1;
        @(posedge clk); #1;
        start_ha = 1'b0; start_hs = 1'b0;
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0);
        idle_bus();
        wait_done_ha("t3");
        @(negedge clk);
        chk("t3_hs_done", 8'(hs_done), 8'd1);

        // Coverage gating: ten 00 vectors then 01/10/11
        q_ha.push_back(mk(1'b1, 8'd0, 8'd13, 4'hF, 1'b0, 4'h0));
        pulse_ha();
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("gate_done_12", 8'(ha_done), 8'd0);
        chk("gate_vec_12",  ha_vec, 8'd12);
        chk("gate_cov_12",  8'(ha_cov), 8'h7);
        send(1'b1, 1'b1, 1'b0, 1'b1);
        idle_bus();
        @(negedge clk);
        chk("gate_done_13", 8'(ha_done), 8'd1);

        // Restart mid-run; the vector coincident with start is discarded
        pulse_ha();
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        idle_bus();
        @(negedge clk);
        chk("mid_vec_2", ha_vec, 8'd2);
        start_ha = 1'b1;
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_sum = 1'b1; in_carry = 1'b1;
        @(posedge clk); #1;
        start_ha = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("restart_vec",  ha_vec, 8'd0);
        chk("restart_err",  ha_err, 8'd0);
        chk("restart_cov",  8'(ha_cov), 8'd0);
        chk("restart_fv",   8'(ha_fv), 8'd0);
        chk("restart_busy", 8'(ha_busy), 8'd1);
        q_ha.push_back(mk(1'b1, 8'd0, 8'd4, 4'hF, 1'b0, 4'h0));
        send(1'b1, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        idle_bus();
        wait_done_ha("t5");

        // rst overrides a held start mid-run
        pulse_ha();
        send(1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b0);
        idle_bus();
        @(negedge clk);
        chk("prerst_err", ha_err, 8'd1);
        rst = 1'b1; start_ha = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_ha_reset("midrst");
        rst = 1'b0; start_ha = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("postrst_busy", 8'(ha_busy), 8'd0);

        repeat (3) @(negedge clk);
        chk("q_ha_empty", 8'(q_ha.size()), 8'd0);
        chk("q_hs_empty", 8'(q_hs.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
